// File: rtl/add_sub_pkg.sv
// Shared types for the pipelined ARM add/sub datapath: operation encoding,
// NZCV flag layout and the carry-seed rule for each operation.
package add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // SUB is a + ~b + 1; ADC/SBC take the incoming C flag instead.
  function automatic logic carry_seed(alu_op_t op, logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// One CW-bit slice of the carry chain: sum, carry out, carry into the slice
// MSB (for the overflow flag) and an all-zero indication.
module add_sub_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] sum_o,
  output logic          cout_o,
  output logic          cmsb_o,
  output logic          zero_o
);

  logic [CW:0] total;

  assign total  = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, cin_i};
  assign sum_o  = total[CW-1:0];
  assign cout_o = total[CW];
  assign cmsb_o = a_i[CW-1] ^ b_i[CW-1] ^ total[CW-1];
  assign zero_o = (total[CW-1:0] == '0);

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined ADD/SUB/ADC/SBC: carry chain split into STAGES registered chunks,
// NZCV from the last stage. Define ADD_SUB_SAT_EN for signed saturation + sat.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags,
  output logic             sat
);

  localparam int STG_SAFE = (STAGES < 1) ? 1 : STAGES;
  localparam int CW       = WIDTH / STG_SAFE;

  if ((STAGES < 1) || ((WIDTH % STG_SAFE) != 0)) begin : g_param_chk
    $error("add_sub_pipe: STAGES must be at least 1 and divide WIDTH");
  end

  logic             stall;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

  // No skid buffer: a stalled output freezes every stage, bubbles included.
  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;
  assign b_eff    = op[0] ? ~b : b;
  assign carry0   = carry_seed(alu_op_t'(op), cin);

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * CW;
    localparam int RW = WIDTH - LO;

    logic [RW-1:0]    a_src;
    logic [RW-1:0]    b_src;
    logic             c_src;
    logic             z_src;
    logic             vld_src;
    logic             vld_q;
    logic [LO+CW-1:0] s_d;
    logic [CW-1:0]    ch_sum;
    logic             ch_cout;
    logic             ch_cmsb;
    logic             ch_zero;

    add_sub_chunk #(.CW(CW)) u_chunk (
      .a_i    (a_src[CW-1:0]),
      .b_i    (b_src[CW-1:0]),
      .cin_i  (c_src),
      .sum_o  (ch_sum),
      .cout_o (ch_cout),
      .cmsb_o (ch_cmsb),
      .zero_o (ch_zero)
    );

    if (k == 0) begin : g_head
      assign a_src   = a;
      assign b_src   = b_eff;
      assign c_src   = carry0;
      assign z_src   = 1'b1;
      assign vld_src = in_valid;
      assign s_d     = ch_sum;
    end else begin : g_link
      assign a_src   = g_stg[k-1].g_mid.a_q;
      assign b_src   = g_stg[k-1].g_mid.b_q;
      assign c_src   = g_stg[k-1].g_mid.c_q;
      assign z_src   = g_stg[k-1].g_mid.z_q;
      assign vld_src = g_stg[k-1].vld_q;
      assign s_d     = {ch_sum, g_stg[k-1].g_mid.s_q};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= 1'b0;
      end else if (adv) begin
        vld_q <= vld_src;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      // Operand bits above this chunk ride along until their stage.
      logic [RW-CW-1:0] a_q;
      logic [RW-CW-1:0] b_q;
      logic [LO+CW-1:0] s_q;
      logic             c_q;
      logic             z_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          z_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_src[RW-1:CW];
          b_q <= b_src[RW-1:CW];
          s_q <= s_d;
          c_q <= ch_cout;
          z_q <= z_src & ch_zero;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] y_d;
      logic [WIDTH-1:0] y_q;
      flags_t           fl_d;
      flags_t           fl_q;
      logic             sat_d;
      logic             v_raw;

      assign v_raw = ch_cmsb ^ ch_cout;

`ifdef ADD_SUB_SAT_EN
      localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;
      logic sat_q;

      always_comb begin
        y_d   = s_d;
        sat_d = 1'b0;
        if (v_raw) begin
          sat_d = 1'b1;
          y_d   = a_src[RW-1] ? SAT_NEG : SAT_POS;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sat_q <= 1'b0;
        end else if (adv) begin
          sat_q <= sat_d;
        end
      end

      assign sat = sat_q;
`else
      assign y_d   = s_d;
      assign sat_d = 1'b0;
      assign sat   = sat_d;
`endif

      // A clamped result is never zero; C and V keep the raw sum.
      always_comb begin
        fl_d   = '0;
        fl_d.n = y_d[WIDTH-1];
        fl_d.z = z_src & ch_zero & ~sat_d;
        fl_d.c = ch_cout;
        fl_d.v = v_raw;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          y_q  <= '0;
          fl_q <= '0;
        end else if (adv) begin
          y_q  <= y_d;
          fl_q <= fl_d;
        end
      end

      assign out_valid     = vld_q;
      assign y             = y_q;
      assign flags[FLAG_N] = fl_q.n;
      assign flags[FLAG_Z] = fl_q.z;
      assign flags[FLAG_C] = fl_q.c;
      assign flags[FLAG_V] = fl_q.v;
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe (WIDTH=8, STAGES=2): directed vectors,
// output stall window, mid-flight reset and latency checks.
module tb_add_sub_pipe;
  import add_sub_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;
  logic         sat;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_lo = 1000000;
  int stall_hi = -1;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] y;
    logic [3:0] f;
    logic [7:0] ys;
    logic [3:0] fs;
    logic       s;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [3:0] f;
    logic       s;
    int         acc;
    bit         lat;
    int         id;
  } exp_t;

  exp_t sb[$];

  // op, a, b, cin | wrapped y, NZCV | saturated y, NZCV, sat
  vec_t vecs [14] = '{
    '{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'h9, 8'h7F, 4'h1, 1'b1},
    '{OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 4'h6, 8'h00, 4'h6, 1'b0},
    '{OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 4'h8, 8'hFF, 4'h8, 1'b0},
    '{OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 4'h6, 8'h00, 4'h6, 1'b0},
    '{OP_SBC, 8'h05, 8'h02, 1'b0, 8'h02, 4'h2, 8'h02, 4'h2, 1'b0},
    '{OP_ADD, 8'h80, 8'hFF, 1'b0, 8'h7F, 4'h3, 8'h80, 4'hB, 1'b1},
    '{OP_ADD, 8'h12, 8'h34, 1'b0, 8'h46, 4'h0, 8'h46, 4'h0, 1'b0},
    '{OP_SUB, 8'h80, 8'h01, 1'b1, 8'h7F, 4'h3, 8'h80, 4'hB, 1'b1},
    '{OP_ADC, 8'h7F, 8'h7F, 1'b0, 8'hFE, 4'h9, 8'h7F, 4'h1, 1'b1},
    '{OP_SBC, 8'h00, 8'h00, 1'b1, 8'h00, 4'h6, 8'h00, 4'h6, 1'b0},
    '{OP_ADD, 8'h00, 8'h00, 1'b1, 8'h00, 4'h4, 8'h00, 4'h4, 1'b0},
    '{OP_SBC, 8'h10, 8'h01, 1'b0, 8'h0E, 4'h2, 8'h0E, 4'h2, 1'b0},
    '{OP_ADD, 8'hAA, 8'h55, 1'b0, 8'hFF, 4'h8, 8'hFF, 4'h8, 1'b0},
    '{OP_SUB, 8'h7F, 8'h80, 1'b0, 8'hFF, 4'h9, 8'h7F, 4'h1, 1'b1}
  };

  add_sub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : ready_gen
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    end
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic issue(input int i, input bit push, input bit lat, output int acc);
    int   n;
    exp_t e;
    @(negedge clk);
    op       = vecs[i].op;
    a        = vecs[i].a;
    b        = vecs[i].b;
    cin      = vecs[i].cin;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: vector %0d got in_ready=0 want 1", i);
      in_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      if (push) begin
`ifdef ADD_SUB_SAT_EN
        e.y = vecs[i].ys;
        e.f = vecs[i].fs;
        e.s = vecs[i].s;
`else
        e.y = vecs[i].y;
        e.f = vecs[i].f;
        e.s = 1'b0;
`endif
        e.acc = acc;
        e.lat = lat;
        e.id  = i;
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin : monitor
    logic [7:0] hy;
    logic [3:0] hf;
    logic       hs;
    bit         held;
    exp_t       e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
        if (held && out_valid) begin
          chk("hold_y", {24'd0, y}, {24'd0, hy});
          chk("hold_flags", {28'd0, flags}, {28'd0, hf});
          chk("hold_sat", {31'd0, sat}, {31'd0, hs});
        end
        held = 1'b0;
        if (out_valid && !out_ready) begin
          held = 1'b1;
          hy   = y;
          hf   = flags;
          hs   = sat;
        end else if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got y=0x%0h want no beat", y);
          end else begin
            e = sb.pop_front();
            chk($sformatf("y[v%0d]", e.id), {24'd0, y}, {24'd0, e.y});
            chk($sformatf("nzcv[v%0d]", e.id), {28'd0, flags}, {28'd0, e.f});
            chk($sformatf("sat[v%0d]", e.id), {31'd0, sat}, {31'd0, e.s});
            if (e.lat) chk($sformatf("latency[v%0d]", e.id), cyc - e.acc, S);
          end
        end
      end
    end
  end

  initial begin : driver
    int acc;
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_y", {24'd0, y}, 0);
    chk("rst_flags", {28'd0, flags}, 0);
    chk("rst_sat", {31'd0, sat}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      issue(i, 1'b1, 1'b1, acc);
      idle(3);
    end

    issue(5, 1'b1, 1'b0, acc);
    stall_lo = acc + 2;
    stall_hi = acc + 4;
    for (int i = 6; i < 9; i++) issue(i, 1'b1, 1'b0, acc);
    idle(8);

    issue(9, 1'b0, 1'b0, acc);
    stall_lo = acc + 2;
    stall_hi = acc + 2;
    issue(10, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("inflight_valid", {31'd0, out_valid}, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_valid", {31'd0, out_valid}, 0);
    chk("post_rst_y", {24'd0, y}, 0);
    chk("post_rst_flags", {28'd0, flags}, 0);
    idle(6);

    issue(11, 1'b1, 1'b1, acc);
    issue(12, 1'b1, 1'b0, acc);
    issue(13, 1'b1, 1'b0, acc);
    idle(1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", sb.size());
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
Parametrised, pipelined adder/subtractor for the ARM datapath, the next generation of the combinational mux_not + fulladder add/sub pair. The carry chain is split into STAGES equal chunks with a register between chunks. Operations are ADD, SUB, ADC and SBC. The block produces ARM NZCV flags and uses valid/ready handshakes on both sides. It sits behind the ALU operand muxes and feeds the writeback and CPSR flag logic.

Parameters:
WIDTH, 32, operand and result width in bits.
STAGES, 4, number of pipeline stages and carry-chain chunks; must be at least 1 and divide WIDTH. Elaboration fails with $error otherwise.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC
cin  in  1  carry in (C flag); used only by ADC/SBC
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result
y  out  WIDTH  result
flags  out  4  {N,Z,C,V}
sat  out  1  saturation occurred (Q); tied 0 unless ADD_SUB_SAT_EN

Behaviour:
- Reset (synchronous, active-high): on the edge where reset=1, every stage valid bit clears. out_valid=0, y=0, flags=0, sat=0. Beats in flight are discarded. in_ready=1 from the first cycle after reset deasserts.
- Accept and stall:
  - A beat is accepted when in_valid && in_ready.
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - A stall freezes every stage, including bubbles. There is no skid buffer.
- Operand formation:
  - b_eff = op[0] ? ~b : b.
  - carry0 = ADD:0, SUB:1, ADC:cin, SBC:cin.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no stall. Throughput is 1 beat per cycle.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff (CW = WIDTH/STAGES bits) plus the carry from stage k-1.
  - Registers that chunk's sum, the carry-out and a running all-zero bit.
  - Higher chunks of a and b_eff travel in delay registers.
- Last stage computes the flags:
  - N = y[WIDTH-1].
  - Z = running zero AND (final chunk == 0).
  - C = carry out of bit WIDTH-1 (ARM convention: SUB C=1 means no borrow).
  - V = carry into MSB XOR carry out of MSB.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- Beat order is preserved. No beat is dropped or duplicated under any out_ready pattern.
- While out_valid=1 and out_ready=0, y, flags and sat hold stable.
- in_valid with in_ready=0 has no effect. The producer must hold the beat.

Optional Feature:
Macro ADD_SUB_SAT_EN.
- Defined: when V=1 the result is clamped to signed saturation: 0x7F..F if a[MSB]=0, else 0x80..0. sat=1 for that beat. N and Z reflect the clamped y. C and V still reflect the unsaturated sum.
- Undefined: y is the wrapped sum, sat is tied 0, and no clamp logic is generated.

Decomposition:
- Package add_sub_pkg:
  - alu_op_t enum (OP_ADD, OP_SUB, OP_ADC, OP_SBC).
  - flags_t packed struct {n,z,c,v}.
  - Index constants FLAG_N..FLAG_V.
- Sub-module add_sub_chunk, parametrised by CW: combinational chunk adder taking a, b_eff and cin, producing sum, cout, carry-into-MSB and is_zero. add_sub_pipe instantiates STAGES copies plus the stage registers.

Test Plan:
- WIDTH=8, STAGES=2, ADD 0x7F+0x01 -> y=0x80, NZCV=1001, out_valid exactly 2 cycles after accept.
- SUB 0x05-0x05 -> y=0x00, NZCV=0110. SUB 0x00-0x01 -> y=0xFF, NZCV=1000.
- ADC 0xFF+0x00 cin=1 -> y=0x00, NZCV=0110. SBC 0x05-0x02 cin=0 -> y=0x02, NZCV=0010.
- Back-to-back 4 beats with out_ready=0 for cycles 2-4 -> in_ready low during the stall, outputs held stable, all 4 results delivered in order.
- reset=1 for one cycle with 2 beats in flight -> out_valid=0 next cycle, nothing emitted afterwards, and a fresh beat has 2-cycle latency.
- ADD_SUB_SAT_EN defined: ADD 0x7F+0x01 -> y=0x7F, sat=1, V=1. ADD 0x80+0xFF -> y=0x80, sat=1. Undefined: sat always 0.
